serial_compare_frame_driver: RTL and testbench

Frames one comparison for a bit-serial magnitude comparator whose outputs are combinational and whose state clears on a synchronous reset. The block accepts two parallel W-bit operands over a valid/ready handshake and pulses the comparator's reset. It then shifts both operands out one bit per cycle, in the configured order, and captures the comparator's final verdict into a held result with its own valid/ready handshake. It sits directly around the comparator, driving its `rst`/`a`/`b` and consuming its `a_less_b`/`a_eq_b`/`a_greater_b`.

---
 rtl/serial_compare_pkg.sv | 19 +
 rtl/parallel_to_serial_shifter.sv | 34 +++
 rtl/serial_compare_frame_driver.sv | 153 +++++++++++++++
 tb/tb_serial_compare_frame_driver.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_compare_pkg.sv
// Shared types and helpers for the serial comparator frame driver.
package serial_compare_pkg;

  // Framing FSM states: wait for operands, clear comparator, shift bits, hold result.
  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_clear = 2'd1,
    st_shift = 2'd2,
    st_done  = 2'd3
  } state_t;

  // True when the comparator's three verdict lines are not exactly one-hot.
  function automatic logic not_one_hot(input logic less, input logic eq, input logic greater);
    logic [2:0] v;
    v = {less, eq, greater};
    return !((v == 3'b100) || (v == 3'b010) || (v == 3'b001));
  endfunction

endpackage

// File: rtl/parallel_to_serial_shifter.sv
// Parallel-load shift register presenting one bit per cycle at q.
// MSB_FIRST selects which end is the head; vacated positions fill with 0.
module parallel_to_serial_shifter #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q
);

  logic [W-1:0] r_sh;

  // Load takes priority over shift; the head bit advances once per shift cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else if (load) begin
      r_sh <= d;
    end else if (shift) begin
      if (MSB_FIRST) begin
        r_sh <= {r_sh[W-2:0], 1'b0};
      end else begin
        r_sh <= {1'b0, r_sh[W-1:1]};
      end
    end
  end

  assign q = MSB_FIRST ? r_sh[W-1] : r_sh[0];

endmodule

// File: rtl/serial_compare_frame_driver.sv
// Frames one comparison for a bit-serial magnitude comparator: accepts an
// operand pair, pulses the comparator reset, shifts W bits of each operand,
// and holds the final verdict until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is only high in IDLE (and low during rst);
// out_valid is high in DONE and stays high, with stable results, until
// out_ready is sampled high.
module serial_compare_frame_driver
  import serial_compare_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         cmp_rst,
  output logic         cmp_a,
  output logic         cmp_b,
  input  logic         cmp_less,
  input  logic         cmp_eq,
  input  logic         cmp_greater,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_less,
  output logic         out_eq,
  output logic         out_greater,
  output logic         out_err,
  output state_t       dbg_state
);

  localparam int           CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_clear;
  logic          r_shift;
  logic          r_out_valid;
  logic          r_less;
  logic          r_eq;
  logic          r_greater;
  logic          r_err;

  logic          w_accept;
  logic          w_qa;
  logic          w_qb;

  // A pair is taken only in IDLE and never while reset is held.
  assign w_accept = in_valid & in_ready;

  parallel_to_serial_shifter #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_a (
    .clk   (clk),
    .rst   (rst),
    .load  (w_accept),
    .shift (r_shift),
    .d     (in_a),
    .q     (w_qa)
  );

  parallel_to_serial_shifter #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_b (
    .clk   (clk),
    .rst   (rst),
    .load  (w_accept),
    .shift (r_shift),
    .d     (in_b),
    .q     (w_qb)
  );

  // Framing FSM: state, bit counter, registered strobes and captured verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= st_idle;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_clear     <= 1'b0;
      r_shift     <= 1'b0;
      r_out_valid <= 1'b0;
      r_less      <= 1'b0;
      r_eq        <= 1'b0;
      r_greater   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        st_idle: begin
          if (w_accept) begin
            r_state    <= st_clear;
            r_in_ready <= 1'b0;
            r_clear    <= 1'b1;
          end
        end
        st_clear: begin
          r_state <= st_shift;
          r_clear <= 1'b0;
          r_shift <= 1'b1;
          r_cnt   <= '0;
        end
        st_shift: begin
          if (r_cnt == LAST) begin
            // The comparator's combinational outputs now cover all W bits.
            r_less      <= cmp_less;
            r_eq        <= cmp_eq;
            r_greater   <= cmp_greater;
            r_err       <= not_one_hot(cmp_less, cmp_eq, cmp_greater);
            r_state     <= st_done;
            r_shift     <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        st_done: begin
          if (out_ready) begin
            r_state     <= st_idle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= st_idle;
          r_in_ready  <= 1'b1;
          r_clear     <= 1'b0;
          r_shift     <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Block reset also clears the comparator so both start in a known state.
  assign cmp_rst     = rst | r_clear;
  assign cmp_a       = r_shift & w_qa;
  assign cmp_b       = r_shift & w_qb;
  assign in_ready    = r_in_ready & ~rst;
  assign out_valid   = r_out_valid & ~rst;
  assign out_less    = r_less;
  assign out_eq      = r_eq;
  assign out_greater = r_greater;
  assign out_err     = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_compare_frame_driver.sv
// Directed bench for serial_compare_frame_driver: one MSB-first and one
// LSB-first instance, each wrapped around a bit-serial comparator model.
module tb_serial_compare_frame_driver;
  import serial_compare_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic force_bad = 1'b0;

  // ---------------- MSB-first instance ----------------
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         cmp_rst, cmp_a, cmp_b, cmp_less, cmp_eq, cmp_greater;
  logic         out_valid, out_ready, out_less, out_eq, out_greater, out_err;
  state_t       dbg_state;

  serial_compare_frame_driver #(.W(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cmp_rst(cmp_rst), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_less(cmp_less), .cmp_eq(cmp_eq), .cmp_greater(cmp_greater),
    .out_valid(out_valid), .out_ready(out_ready), .out_less(out_less),
    .out_eq(out_eq), .out_greater(out_greater), .out_err(out_err),
    .dbg_state(dbg_state)
  );

  // MSB-first comparator: first differing bit decides, then the verdict sticks.
  logic [1:0] m_dec;
  logic       m_less, m_eq, m_gt;
  always_comb begin
    m_less = 1'b0; m_eq = 1'b0; m_gt = 1'b0;
    if (m_dec == 2'd1) m_less = 1'b1;
    else if (m_dec == 2'd2) m_gt = 1'b1;
    else if (!cmp_a && cmp_b) m_less = 1'b1;
    else if (cmp_a && !cmp_b) m_gt = 1'b1;
    else m_eq = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (cmp_rst) m_dec <= 2'd0;
    else m_dec <= m_less ? 2'd1 : (m_gt ? 2'd2 : 2'd0);
  end
  assign cmp_less    = m_less | force_bad;
  assign cmp_greater = m_gt | force_bad;
  assign cmp_eq      = m_eq;

  // ---------------- LSB-first instance ----------------
  logic         l_in_valid, l_in_ready;
  logic [W-1:0] l_in_a, l_in_b;
  logic         l_cmp_rst, l_cmp_a, l_cmp_b, l_cmp_less, l_cmp_eq, l_cmp_greater;
  logic         l_out_valid, l_out_ready, l_out_less, l_out_eq, l_out_greater, l_out_err;
  state_t       l_dbg_state;

  serial_compare_frame_driver #(.W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_a(l_in_a), .in_b(l_in_b), .cmp_rst(l_cmp_rst), .cmp_a(l_cmp_a), .cmp_b(l_cmp_b),
    .cmp_less(l_cmp_less), .cmp_eq(l_cmp_eq), .cmp_greater(l_cmp_greater),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_less(l_out_less),
    .out_eq(l_out_eq), .out_greater(l_out_greater), .out_err(l_out_err),
    .dbg_state(l_dbg_state)
  );

  // LSB-first comparator: the latest differing bit overrides earlier ones.
  logic [1:0] l_dec;
  always_comb begin
    l_cmp_less = 1'b0; l_cmp_eq = 1'b0; l_cmp_greater = 1'b0;
    if (l_cmp_a && !l_cmp_b) l_cmp_greater = 1'b1;
    else if (!l_cmp_a && l_cmp_b) l_cmp_less = 1'b1;
    else if (l_dec == 2'd1) l_cmp_less = 1'b1;
    else if (l_dec == 2'd2) l_cmp_greater = 1'b1;
    else l_cmp_eq = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (l_cmp_rst) l_dec <= 2'd0;
    else l_dec <= l_cmp_less ? 2'd1 : (l_cmp_greater ? 2'd2 : 2'd0);
  end

  // ---------------- driver tasks ----------------
  // Offer a pair to the MSB instance; returns at the negedge of the CLEAR cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_op_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid on the MSB instance; n counts negedges waited.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_a = '0; l_in_b = '0; l_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, cmp_rst, cmp_a, cmp_b, out_valid} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_during: {in_ready,cmp_rst,cmp_a,cmp_b,out_valid}=%b, required 01000",
               {in_ready, cmp_rst, cmp_a, cmp_b, out_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, cmp_rst, out_valid, l_in_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_after: {in_ready,cmp_rst,out_valid,l_in_ready}=%b, required 1001",
               {in_ready, cmp_rst, out_valid, l_in_ready});
    end
    checks++;
    if (dbg_state !== st_idle || {out_less, out_eq, out_greater, out_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_regs: state=%0d results=%b, required state 0 results 0000",
               dbg_state, {out_less, out_eq, out_greater, out_err});
    end
  endtask

  task automatic test_greater_msb();
    logic [7:0] got_a, got_b;
    logic       early;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL gt_ready: in_ready=%b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (dbg_state !== st_clear || cmp_rst !== 1'b1 || cmp_a !== 1'b0 || cmp_b !== 1'b0) begin
      errors++;
      $display("FAIL gt_clear: state=%0d cmp_rst=%b cmp_a=%b cmp_b=%b, required 1 1 0 0",
               dbg_state, cmp_rst, cmp_a, cmp_b);
    end
    got_a = '0; got_b = '0; early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got_a = {got_a[6:0], cmp_a};
      got_b = {got_b[6:0], cmp_b};
      if (out_valid) early = 1'b1;
    end
    checks++;
    if (got_a !== 8'hA5 || got_b !== 8'h5A) begin
      errors++;
      $display("FAIL gt_serial: a_bits=%h b_bits=%h, required a5 5a", got_a, got_b);
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL gt_early_valid: out_valid seen during shift=%b, required 0", early);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {out_less, out_eq, out_greater, out_err} !== 4'b0010) begin
      errors++;
      $display("FAIL gt_result: out_valid=%b results=%b at accept+10, required 1 0010",
               out_valid, {out_less, out_eq, out_greater, out_err});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== st_idle) begin
      errors++;
      $display("FAIL gt_pulse: out_valid=%b state=%0d, required 0 0", out_valid, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int first_at, second_at, n;
    logic [3:0] first_res;
    first_at = -1; second_at = -1; first_res = '0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h3C;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin in_a = 8'h10; in_b = 8'h11; end
      if (out_valid && first_at < 0) begin
        first_at = k;
        first_res = {out_less, out_eq, out_greater, out_err};
      end
      if (in_ready) begin
        second_at = k;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (first_at != 10 || first_res !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_first: valid_at=%0d results=%b, required 10 0100", first_at, first_res);
    end
    checks++;
    if (second_at != 11) begin
      errors++;
      $display("FAIL b2b_spacing: second accept at %0d, required 11", second_at);
    end
    wait_valid(n);
    checks++;
    if (n != 9 || {out_less, out_eq, out_greater, out_err} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_second: wait=%0d results=%b, required 9 1000",
               n, {out_less, out_eq, out_greater, out_err});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] got_a, got_b;
    logic       first_bit;
    @(negedge clk);
    l_in_valid = 1'b1; l_in_a = 8'h81; l_in_b = 8'h80;
    @(negedge clk);
    l_in_valid = 1'b0;
    got_a = '0; got_b = '0; first_bit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) first_bit = l_cmp_a;
      got_a = {l_cmp_a, got_a[7:1]};
      got_b = {l_cmp_b, got_b[7:1]};
    end
    checks++;
    if (first_bit !== 1'b1) begin
      errors++;
      $display("FAIL lsb_first_bit: cmp_a=%b, required 1", first_bit);
    end
    checks++;
    if (got_a !== 8'h81 || got_b !== 8'h80) begin
      errors++;
      $display("FAIL lsb_serial: a_bits=%h b_bits=%h, required 81 80", got_a, got_b);
    end
    @(negedge clk);
    checks++;
    if (l_out_valid !== 1'b1 || {l_out_less, l_out_eq, l_out_greater, l_out_err} !== 4'b0010) begin
      errors++;
      $display("FAIL lsb_result: out_valid=%b results=%b, required 1 0010",
               l_out_valid, {l_out_less, l_out_eq, l_out_greater, l_out_err});
    end
  endtask

  task automatic test_backpressure();
    int   n;
    logic hold_ok;
    out_ready = 1'b0;
    start_op(8'h20, 8'h40);
    wait_valid(n);
    checks++;
    if (n != 9 || {out_less, out_eq, out_greater, out_err} !== 4'b1000) begin
      errors++;
      $display("FAIL bp_first: wait=%0d results=%b, required 9 1000",
               n, {out_less, out_eq, out_greater, out_err});
    end
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_less, out_eq, out_greater, out_err} !== 4'b1000) hold_ok = 1'b0;
    end
    checks++;
    if (hold_ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: held state broken, out_valid=%b in_ready=%b results=%b, required 1 0 1000",
               out_valid, in_ready, {out_less, out_eq, out_greater, out_err});
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== st_idle || out_less !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b state=%0d out_less=%b, required 0 0 1",
               out_valid, dbg_state, out_less);
    end
  endtask

  task automatic test_reset_mid_shift();
    int   n;
    logic seen;
    start_op(8'hF0, 8'h0F);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dbg_state !== st_shift || cmp_rst !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_assert: state=%0d cmp_rst=%b in_ready=%b, required 2 1 0",
               dbg_state, cmp_rst, in_ready);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== st_idle || out_valid !== 1'b0 ||
        {out_less, out_eq, out_greater, out_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_state: state=%0d out_valid=%b results=%b, required 0 0 0000",
               dbg_state, out_valid, {out_less, out_eq, out_greater, out_err});
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_novalid: out_valid seen=%b, required 0", seen);
    end
    start_op(8'h01, 8'h02);
    wait_valid(n);
    checks++;
    if ({out_less, out_eq, out_greater, out_err} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_next: results=%b, required 1000", {out_less, out_eq, out_greater, out_err});
    end
  endtask

  task automatic test_non_one_hot();
    int n;
    force_bad = 1'b1;
    start_op(8'h90, 8'h10);
    wait_valid(n);
    checks++;
    if ({out_less, out_eq, out_greater, out_err} !== 4'b1011) begin
      errors++;
      $display("FAIL err_flag: results=%b, required 1011", {out_less, out_eq, out_greater, out_err});
    end
    force_bad = 1'b0;
    start_op(8'h07, 8'h07);
    wait_valid(n);
    checks++;
    if ({out_less, out_eq, out_greater, out_err} !== 4'b0100) begin
      errors++;
      $display("FAIL err_clear: results=%b, required 0100", {out_less, out_eq, out_greater, out_err});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_greater_msb();
    test_back_to_back();
    test_lsb_first();
    test_backpressure();
    test_reset_mid_shift();
    test_non_one_hot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
